// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
package mux_arb_pkg;

   localparam int NUM_REQ = 4;

   typedef logic [1:0] req_idx_t;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   function automatic logic [NUM_REQ-1:0] idx2onehot(input req_idx_t idx);
      idx2onehot = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester, grant/select and output-stage signals of the mux arbiter.
interface mux_rr_arbiter_if #(
   parameter int WIDTH = 4
);
   logic             req_a, req_b, req_c, req_d;
   logic [WIDTH-1:0] in_a, in_b, in_c, in_d;
   logic             gnt_a, gnt_b, gnt_c, gnt_d;
   logic             sel_a, sel_b, sel_c, sel_d;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output req_a, req_b, req_c, req_d,
      output in_a, in_b, in_c, in_d,
      output out_ready,
      input  gnt_a, gnt_b, gnt_c, gnt_d,
      input  sel_a, sel_b, sel_c, sel_d,
      input  out, out_valid
   );

   modport slave (
      input  req_a, req_b, req_c, req_d,
      input  in_a, in_b, in_c, in_d,
      input  out_ready,
      output gnt_a, gnt_b, gnt_c, gnt_d,
      output sel_a, sel_b, sel_c, sel_d,
      output out, out_valid
   );
endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Combinational round-robin picker: first asserted, non-excluded request
// searching upward from the slot after the last winner, wrapping d->a.
module mux_rr_pick
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  req_idx_t           i_last,
   input  logic [NUM_REQ-1:0] i_excl,
   output logic               o_found,
   output req_idx_t           o_idx
);

   // Offset NUM_REQ wraps back onto the last winner itself, giving it lowest priority.
   always_comb begin
      o_found = 1'b0;
      o_idx   = 2'd0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!o_found && i_req[i_last + req_idx_t'(k)] && !i_excl[i_last + req_idx_t'(k)]) begin
            o_found = 1'b1;
            o_idx   = i_last + req_idx_t'(k);
         end else begin
            o_found = o_found;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with hold-limited grant tenure, one-hot mux select
// and a single registered output stage with valid/ready backpressure.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX_HOLD = 4
) (
   input  logic           clk,
   input  logic           rst,
   mux_rr_arbiter_if.slave bus
);

   localparam int            HW         = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

   arb_state_t         r_state, w_state_nxt;
   req_idx_t           r_idx, w_idx_nxt;
   req_idx_t           r_last, w_last_nxt;
   logic [HW-1:0]      r_hold, w_hold_nxt;
   logic [NUM_REQ-1:0] r_gnt;
   logic [WIDTH-1:0]   r_out;
   logic               r_out_valid;

   logic [NUM_REQ-1:0] w_req;
   logic [NUM_REQ-1:0] w_excl;
   logic               w_gnt_req, w_accept, w_release, w_found;
   logic [HW-1:0]      w_hold_inc;
   req_idx_t           w_pick_idx;
   logic [WIDTH-1:0]   w_data;

   assign w_req      = {bus.req_d, bus.req_c, bus.req_b, bus.req_a};
   assign w_gnt_req  = w_req[r_idx];
   assign w_accept   = (r_state == GRANT) && w_gnt_req && (!r_out_valid || bus.out_ready);
   assign w_hold_inc = r_hold + HW'(1);
   // A dropped request wins over a simultaneous hold expiry: no accept can occur then.
   assign w_release  = (r_state == GRANT) && (!w_gnt_req || (w_accept && (w_hold_inc == HOLD_LIMIT)));
   assign w_excl     = (r_state == GRANT) ? idx2onehot(r_idx) : 4'b0000;

   mux_rr_pick u_pick (
      .i_req   (w_req),
      .i_last  (r_last),
      .i_excl  (w_excl),
      .o_found (w_found),
      .o_idx   (w_pick_idx)
   );

   // Data mux driven by the currently granted index.
   always_comb begin
      w_data = '0;
      case (r_idx)
         2'd0:    w_data = bus.in_a;
         2'd1:    w_data = bus.in_b;
         2'd2:    w_data = bus.in_c;
         2'd3:    w_data = bus.in_d;
         default: w_data = '0;
      endcase
   end

   // Next state, granted index, last winner and hold count.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_last_nxt  = r_last;
      w_hold_nxt  = r_hold;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt = GRANT;
               w_idx_nxt   = w_pick_idx;
               w_last_nxt  = w_pick_idx;
               w_hold_nxt  = '0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         GRANT: begin
            if (w_release) begin
               w_hold_nxt = '0;
               if (w_found) begin
                  w_idx_nxt  = w_pick_idx;
                  w_last_nxt = w_pick_idx;
               end else if (w_gnt_req) begin
                  w_state_nxt = GRANT;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (w_accept) begin
               w_hold_nxt = w_hold_inc;
            end else begin
               w_hold_nxt = r_hold;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
         end
      endcase
   end

   // State, grant and output-stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= 2'd0;
         r_last      <= 2'd3;
         r_hold      <= '0;
         r_gnt       <= 4'b0000;
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_last  <= w_last_nxt;
         r_hold  <= w_hold_nxt;
         r_gnt   <= (w_state_nxt == GRANT) ? idx2onehot(w_idx_nxt) : 4'b0000;
         if (w_accept) begin
            r_out       <= w_data;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= r_out_valid;
         end
      end
   end

   assign {bus.gnt_d, bus.gnt_c, bus.gnt_b, bus.gnt_a} = r_gnt;
   assign {bus.sel_d, bus.sel_c, bus.sel_b, bus.sel_a} = r_gnt;
   assign bus.out       = r_out;
   assign bus.out_valid = r_out_valid;

endmodule
